// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: forwarding selects,
// load-use stall sequencing, flush on control transfer, memory freeze and perf counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16,
  parameter int R0_ZERO           = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic [4:0]       rp_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             use_rp_id,
  input  logic [4:0]       rd_ex,
  input  logic             wb_ex,
  input  logic             memrd_ex,
  input  logic [4:0]       rd_mem,
  input  logic             wb_mem,
  input  logic [4:0]       rd_wb,
  input  logic             wb_wb,
  input  logic             take_ex,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             kill_fd,
  output logic             stall_de,
  output logic             bubble_de,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [1:0]       fwd_rp,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             busy_lu
);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       hit_ex_rs, hit_ex_rt, hit_ex_rp;
  logic       lu, stall_req, stall_inc, flush_inc;
  logic [1:0] sel_rs, sel_rt, sel_rp;

  function automatic logic hit(input logic use_r, input logic [4:0] r,
                               input logic [4:0] rd, input logic wb);
    return use_r && wb && (r == rd) && !((R0_ZERO != 0) && (r == 5'd0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input logic [4:0] rde, input logic wbe,
                                         input logic [4:0] rdm, input logic wbm,
                                         input logic [4:0] rdw, input logic wbw);
    if (hit(use_r, r, rde, wbe))      return 2'b01;
    else if (hit(use_r, r, rdm, wbm)) return 2'b10;
    else if (hit(use_r, r, rdw, wbw)) return 2'b11;
    else                              return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hit_ex_rs = hit(use_rs_id, rs_id, rd_ex, wb_ex);
  assign hit_ex_rt = hit(use_rt_id, rt_id, rd_ex, wb_ex);
  assign hit_ex_rp = hit(use_rp_id, rp_id, rd_ex, wb_ex);

  assign lu        = memrd_ex && wb_ex && (hit_ex_rs || hit_ex_rt || hit_ex_rp);
  assign stall_req = (state == LU_STALL) || lu;
  assign stall_inc = mem_busy || (!take_ex && stall_req);
  assign flush_inc = !mem_busy && take_ex;

  assign sel_rs = fwd_sel(use_rs_id, rs_id, rd_ex, wb_ex, rd_mem, wb_mem, rd_wb, wb_wb);
  assign sel_rt = fwd_sel(use_rt_id, rt_id, rd_ex, wb_ex, rd_mem, wb_mem, rd_wb, wb_wb);
  assign sel_rp = fwd_sel(use_rp_id, rp_id, rd_ex, wb_ex, rd_mem, wb_mem, rd_wb, wb_wb);

  assign fwd_rs  = rst_n ? sel_rs : 2'b00;
  assign fwd_rt  = rst_n ? sel_rt : 2'b00;
  assign fwd_rp  = rst_n ? sel_rp : 2'b00;
  assign busy_lu = (state == LU_STALL);

  // Control outputs: reset forces a bubble; freeze beats flush beats load-use.
  always_comb begin
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    kill_fd   = 1'b0;
    stall_de  = 1'b0;
    bubble_de = 1'b0;
    if (!rst_n) begin
      bubble_de = 1'b1;
    end else if (mem_busy) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
      stall_de = 1'b1;
    end else if (take_ex) begin
      kill_fd   = 1'b1;
      bubble_de = 1'b1;
    end else if (stall_req) begin
      stall_pc  = 1'b1;
      stall_fd  = 1'b1;
      bubble_de = 1'b1;
    end
  end

  // LU_STALL lasts LOAD_STALL_CYCLES-1 cycles after the detecting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_busy) begin
        state <= state;
      end else if (take_ex) begin
        state <= RUN;
        cnt   <= 3'd0;
      end else if (state == LU_STALL) begin
        if (cnt <= 3'd1) begin
          state <= RUN;
          cnt   <= 3'd0;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end else if (lu && (LOAD_STALL_CYCLES > 1)) begin
        state <= LU_STALL;
        cnt   <= CNT_INIT;
      end

      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
        if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule
